psum_drain: RTL
===============

# psum_drain

Read-side controller for the PE partial-sum scratchpad FIFO. It tracks scratchpad occupancy by monitoring the write strobe. On a start command it issues exactly `len` read strobes, never reading an empty scratchpad. It absorbs the scratchpad's 1-cycle read latency in a 2-entry skid buffer and presents the drained partial sums to the next PE / output NoC port over a valid/ready handshake.

## Interface
- `DEPTH`, 64: scratchpad capacity in entries; `len` and occupancy range 0..DEPTH.
- `DW`, 8: partial-sum data width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: drain command, sampled only in IDLE.
- `len` in 7: number of entries to drain; legal 1..DEPTH.
- `busy` out 1: high while a drain is in progress, through the DONE cycle.
- `done` out 1: single-cycle pulse when the last entry has been accepted downstream.
- `err` out 1: single-cycle pulse on an illegal command.
- `spad_wr_mon` in 1: copy of the scratchpad write strobe, used for occupancy tracking.
- `spad_rd` out 1: scratchpad read strobe; data returns on `spad_data` the next cycle.
- `spad_data` in DW: scratchpad read data.
- `out_valid` out 1: output handshake valid.
- `out_ready` in 1: output handshake ready.
- `out_data` out DW: output data.

## Operation
- **Occupancy counter `level`** (0..DEPTH):
  - +1 on `spad_wr_mon`; −1 on `spad_rd`; unchanged when both occur in the same cycle.
  - Saturates at DEPTH; writes beyond DEPTH are not counted.
  - Never decrements below 0, because `spad_rd` requires `level`>0.
- **FSM states:** IDLE, DRAIN, FLUSH, DONE.
- **IDLE:**
  - `start` with `len` in 1..DEPTH: load `remaining`=`len` and go to DRAIN.
  - `start` with `len`=0 or `len`>DEPTH: pulse `err` and stay in IDLE.
- **DRAIN:**
  - `spad_rd` is asserted iff all of: `remaining`>0, `level`>0, and (`buf_cnt` + `inflight` − `pop`) < 2.
  - `pop` = `out_valid` & `out_ready`.
  - Each read decrements `remaining` and sets `inflight` for one cycle.
  - When `remaining` reaches 0, go to FLUSH.
- **FLUSH:** wait until `inflight`=0 and `buf_cnt`=0, then go to DONE.
- **DONE:** `done`=1 for one cycle, then go to IDLE.
- **`start` outside IDLE:** ignored; no `err` pulse.
- **Skid buffer** (2 entries, FIFO order):
  - Captures `spad_data` in the cycle after each `spad_rd`.
  - `out_valid` = (`buf_cnt`>0); `out_data` = head entry.
  - Push and pop in the same cycle are allowed; the buffer never overflows.
- **Output handshake:**
  - `out_data` is held stable while `out_valid` is high and `out_ready` is low.
  - `out_valid` never drops without a pop.
- **Data path:** `out_data` is the unmodified scratchpad word, apart from the optional ReLU below.

## Timing
- **Reset values:**
  - `busy`=0, `done`=0, `err`=0, `spad_rd`=0, `out_valid`=0, `out_data`=0.
  - `level`=0, `buf_cnt`=0, `inflight`=0; state = IDLE.
- **Latency:**
  - `start` sampled at edge 0.
  - First `spad_rd` in cycle 1, provided `level`>0.
  - First `out_valid` in cycle 3.
- **Throughput:** with `out_ready` held high and `level` sufficient, one `spad_rd` and one output word per cycle.
- **`done` timing:** `done` is asserted the cycle after the final pop.
- **`busy` timing:** high from cycle 1 through the DONE cycle inclusive.
- **Empty scratchpad mid-drain:** reads stall; they resume in the cycle after `level` becomes nonzero.
- **Reset mid-operation:**
  - Aborts the drain; buffered and in-flight data are discarded.
  - No `done` pulse.
  - Outputs return to their reset values on the next edge.

## Configuration
- Macro `PSUM_DRAIN_RELU_EN`.
- **Defined:** the buffer input is rectified before capture. Data is treated as two's-complement; any value with MSB=1 is replaced by 0. Latency is unchanged.
- **Undefined:** data passes through unmodified.

## Test plan
- **Basic drain:** 4 writes (0x11, 0x22, 0x33, 0x44), then `start`, `len`=4, `out_ready`=1 → `spad_rd` in cycles 1–4; `out_data` 0x11..0x44 in cycles 3–6; `done` in cycle 7; `level`=0.
- **Backpressure:** `len`=3 with 3 entries present; `out_ready` low for cycles 3–8 → at most 2 reads outstanding; `out_data`=first word is held stable; all 3 words are delivered in order once `out_ready` rises.
- **Empty stall:** `start`, `len`=2 with `level`=0 → no `spad_rd` is issued. A write in cycle 5 → `spad_rd` in cycle 6. A second write in cycle 9 → `spad_rd` in cycle 10, then `done`.
- **Illegal command:** `len`=0, then `len`=65 → `err` pulses each time; `busy` stays 0. `start` while `busy` is high → ignored.
- **Reset mid-drain:** `rst_n` low during cycle 4 of an 8-entry drain → all outputs are 0 the next cycle; a subsequent `start` with `len`=1 after 1 write drains correctly.
- **ReLU:** with `PSUM_DRAIN_RELU_EN` defined, drain 0x85 and 0x05 → `out_data` 0x00 then 0x05. Undefined → 0x85 then 0x05.

Source files
------------

// File: rtl/psum_drain_if.sv
// Output stream bundle for psum_drain: drained partial sums toward the next PE / NoC port.
// Latency: none, plain wires.
// Backpressure: ready from the sink stalls the producer; data held while valid && !ready.
//
// Ports (via modports):
//   master - drives valid/data, samples ready (psum_drain side)
//   slave  - samples valid/data, drives ready (consumer side)
interface psum_drain_if #(
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/psum_drain.sv
// Read-side drain controller for the PE partial-sum scratchpad FIFO.
// Latency: start sampled at edge 0, first spad_rd in cycle 1, first out.valid in cycle 3.
// Backpressure: reads throttle so a 2-entry skid buffer never overflows; out.data held while stalled.
//
// Ports:
//   clk, rst_n        - single clock, synchronous active-low reset
//   start, len        - drain command (sampled in IDLE only) and entry count, legal 1..DEPTH
//   busy, done, err   - drain in progress / one-cycle completion pulse / one-cycle illegal-len pulse
//   spad_wr_mon       - copy of the scratchpad write strobe, drives the occupancy counter
//   spad_rd/spad_data - scratchpad read strobe and its data, returned one cycle later
//   out               - valid/ready output stream (psum_drain_if.master)
// Build option: define PSUM_DRAIN_RELU_EN to rectify words (MSB set -> 0) before buffering.
module psum_drain #(
    parameter int DEPTH = 64,
    parameter int DW    = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [$clog2(DEPTH+1)-1:0]   len,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    input  logic                         spad_wr_mon,
    output logic                         spad_rd,
    input  logic [DW-1:0]                spad_data,
    psum_drain_if.master                 out
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] level;
    logic [CW-1:0] remaining;
    logic          inflight;
    logic [1:0]    buf_cnt;
    logic [DW-1:0] buf0, buf1;
    logic          err_q;
    logic          pop;
    logic          len_ok;
    logic [2:0]    occ;
    logic [DW-1:0] din;

    assign pop       = out.valid & out.ready;
    assign out.valid = (buf_cnt != 2'd0);
    assign out.data  = buf0;
    assign err       = err_q;
    assign len_ok    = (len != '0) && (len <= CW'(DEPTH));

    // Slots the buffer will need once this cycle's pop and the in-flight word settle.
    assign occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};

`ifdef PSUM_DRAIN_RELU_EN
    assign din = spad_data[DW-1] ? '0 : spad_data;
`else
    assign din = spad_data;
`endif

    always_comb begin
        state_nxt = state;
        spad_rd   = 1'b0;
        busy      = (state != S_IDLE);
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && len_ok) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                spad_rd = (remaining != '0) && (level != '0) && (occ < 3'd2);
                if (spad_rd && (remaining == CW'(1))) state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                // Leave as soon as the last word is being popped so done lands the cycle after.
                if (!inflight && (buf_cnt == {1'b0, pop})) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            inflight  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= spad_rd;
            err_q    <= (state == S_IDLE) && start && !len_ok;
            if ((state == S_IDLE) && start && len_ok)
                remaining <= len;
            else if (spad_rd)
                remaining <= remaining - CW'(1);
        end
    end

    // Occupancy: a simultaneous write and read cancel; writes into a full scratchpad are lost.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({spad_wr_mon, spad_rd})
                2'b10:   if (level != CW'(DEPTH)) level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Two-entry skid buffer, buf0 is the head.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
        end else begin
            case ({inflight, pop})
                2'b10: begin
                    if (buf_cnt == 2'd0) buf0 <= din;
                    else                 buf1 <= din;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= din;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
